fp_mul_pipe: RTL and testbench
==============================

// Module: fp_mul_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-754-style floating-point multiplier. It is the
//  clocked successor to the combinational fp32 multiply wrapper.
//  Width is set by EXP_W/MAN_W (defaults give binary32). Input and output use
//  valid/ready handshakes with full backpressure.
//  Feeds the force/accumulate datapath, where one result per cycle is needed
//  and downstream stalls occur.
// PARAMETERS
//  EXP_W    8    exponent field width (>=3)
//  MAN_W    23   stored mantissa width, hidden bit excluded (>=2)
//  TAG_W    1    width of a user sideband carried alongside each operand pair
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          a/b/in_tag valid
//  in_ready   out  1          block accepts operands this cycle
//  a          in   EXP_W+MAN_W+1  operand A {sign,exp,man}
//  b          in   EXP_W+MAN_W+1  operand B
//  in_tag     in   TAG_W      sideband, returned unchanged with the result
//  out_valid  out  1          o/out_tag valid
//  out_ready  in   1          consumer accepts result
//  o          out  EXP_W+MAN_W+1  A*B
//  out_tag    out  TAG_W      sideband of this result
//  flags      out  4          {invalid,overflow,underflow,inexact}; only with FP_MUL_FLAGS_EN
// BEHAVIOUR
//  Reset: all stage valid bits are cleared, so out_valid=0. o, out_tag and flags are 0.
//  Reset mid-operation discards in-flight results with no output.
//  Handshake: a transfer occurs on a cycle where valid&&ready.
//   - stall = out_valid && !out_ready
//   - in_ready = !stall
//   - in_ready is combinational from out_ready; there is no skid buffer.
//   - While stall is asserted, every pipeline register holds.
//   - Otherwise the pipeline advances one stage per cycle. Bubbles advance as well.
//  Latency: exactly 3 cycles accept-to-out_valid when not stalled. Throughput is 1/cycle.
//   - S1: unpack operands, classify (zero/inf/nan/normal), sign = sa^sb,
//     exp sum = ea+eb-BIAS computed in EXP_W+2 signed bits.
//   - S2: product of (MAN_W+1)x(MAN_W+1) significands -> 2*MAN_W+2 bits.
//   - S3: normalise (shift 1 if MSB set, exp+1), round, pack, apply specials.
//  Order is preserved, and each tag stays paired with its own result.
//  Rounding: round-to-nearest-even using guard bit and sticky (OR of the rest).
//   A mantissa carry-out from rounding increments the exponent.
//  Subnormal inputs: an exp field of 0 is treated as zero, with the sign kept (FTZ).
//  Subnormal and underflow results: a final biased exp <=0 gives signed zero (FTZ).
//  Overflow: a final biased exp >= 2^EXP_W-1 gives signed infinity.
//  Specials, in priority order:
//   - NaN input, or inf*0 -> canonical qNaN {0,all-ones,1,0...0}
//   - inf*x -> signed inf
//   - 0*x -> signed zero
//  Boundaries:
//   - in_valid may drop while stalled; the accepted data is unaffected.
//   - out_ready toggling every cycle must not drop or duplicate results.
//   - A simultaneous accept and output in the same cycle is legal.
// CONFIGURATION
//  FP_MUL_FLAGS_EN defined:
//   - flags port is present and registered, aligned with o.
//   - invalid = NaN input or inf*0.
//   - overflow = result became inf from finite operands.
//   - underflow = a nonzero exact result was flushed to zero.
//   - inexact = any discarded nonzero bits, or overflow/underflow.
//  FP_MUL_FLAGS_EN undefined:
//   - no flags port and no flag logic.
//   - o, latency and handshake are identical to the defined case.
// TESTING (defaults, binary32)
//  - Basic product, out_ready=1:
//    a=0x40000000, b=0x40400000 accepted at cycle t -> o=0x40C00000 with out_valid at t+3.
//  - Round-to-nearest-even:
//    0x3F800001*0x3F800001 -> 0x3F800002, inexact=1 (flags build).
//  - Specials:
//    0x7F800000*0x00000000 -> 0x7FC00000, invalid=1;
//    0xFF800000*0x40000000 -> 0xFF800000.
//  - Overflow/underflow:
//    0x7F000000*0x7F000000 -> 0x7F800000, overflow=1;
//    0x00800000*0x3F000000 -> 0x00000000, underflow=1.
//  - Backpressure:
//    stream 8 pairs with tags 0..7 and hold out_ready=0 for 5 cycles mid-stream ->
//    all 8 results appear in tag order, none lost or duplicated, in_ready=0 while stalled.
//  - Reset mid-stream:
//    assert rst for 1 cycle with 3 results in flight -> out_valid=0 on the next cycle,
//    no stale results emerge, and the next accepted pair returns after 3 cycles.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined floating-point multiplier (binary32 by default).
//
// Operands use the {sign, exp, man} layout given by EXP_W/MAN_W. Subnormal inputs
// and results are flushed to signed zero. Rounding is round-to-nearest-even.
//
// Optional feature macro: FP_MUL_FLAGS_EN adds a registered 'flags' port
// {invalid, overflow, underflow, inexact} that is aligned with 'o'.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, in_tag)
//   a, b                operands {sign, exp, man}
//   in_tag              user sideband returned unchanged with its result
//   out_valid/out_ready result handshake (o, out_tag[, flags])
//   o                   a*b
//   out_tag             sideband of this result
//   flags               (FP_MUL_FLAGS_EN only) exception flags
//
// Handshake: a transfer happens on any cycle where valid && ready. The pipeline
// stalls as a whole when the output holds a result the consumer refuses
// (out_valid && !out_ready); in_ready is the combinational inverse of that stall.
// Otherwise every stage, bubbles included, advances once per cycle, giving a
// fixed three-cycle accept-to-out_valid latency.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   o,
    output logic [TAG_W-1:0]       out_tag
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic [3:0]             flags
`endif
);

    localparam int W    = EXP_W + MAN_W + 1;
    localparam int EW   = EXP_W + 2;          // signed exponent working width
    localparam int PW   = 2 * MAN_W + 2;      // full significand product width
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EW-1:0] BIAS_S  = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [W-1:0]         QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // ------------------------------------------------------------------
    // Stage 1: unpack and classify
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [EW-1:0] exp_sum_c;

    assign ea = a[W-2:MAN_W];
    assign eb = b[W-2:MAN_W];
    assign ma = a[MAN_W-1:0];
    assign mb = b[MAN_W-1:0];

    // exp field 0 covers both true zero and subnormals (flushed to zero)
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (ma == '0);
    assign b_inf  = (eb == EXP_ONES) && (mb == '0);
    assign a_nan  = (ea == EXP_ONES) && (ma != '0);
    assign b_nan  = (eb == EXP_ONES) && (mb != '0);

    assign exp_sum_c = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;

    logic                 s1_valid;
    logic [TAG_W-1:0]     s1_tag;
    logic                 s1_sign;
    logic signed [EW-1:0] s1_exp;
    logic [MAN_W:0]       s1_siga, s1_sigb;
    logic                 s1_inv, s1_inf, s1_zero;

    // ------------------------------------------------------------------
    // Stage 2: significand product
    // ------------------------------------------------------------------
    logic [PW-1:0] prod_c;
    assign prod_c = {{(MAN_W+1){1'b0}}, s1_siga} * {{(MAN_W+1){1'b0}}, s1_sigb};

    logic                 s2_valid;
    logic [TAG_W-1:0]     s2_tag;
    logic                 s2_sign;
    logic signed [EW-1:0] s2_exp;
    logic [PW-1:0]        s2_prod;
    logic                 s2_inv, s2_inf, s2_zero;

    // ------------------------------------------------------------------
    // Stage 3: normalise, round, pack, specials
    // ------------------------------------------------------------------
    logic                 top;
    logic [MAN_W-1:0]     mant_n;
    logic                 guard, sticky, round_up;
    logic [MAN_W:0]       mant_r;
    logic signed [EW-1:0] exp_n, exp_f;
    logic                 ovf, unf;
    logic [W-1:0]         res_c;

    // Product of two [1,2) significands lies in [1,4); the MSB tells which.
    assign top = s2_prod[PW-1];

    always_comb begin
        mant_n = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        if (top) begin
            mant_n = s2_prod[PW-2:MAN_W+1];
            guard  = s2_prod[MAN_W];
            sticky = |s2_prod[MAN_W-1:0];
        end else begin
            mant_n = s2_prod[PW-3:MAN_W];
            guard  = s2_prod[MAN_W-1];
            sticky = |s2_prod[MAN_W-2:0];
        end
    end

    assign exp_n    = s2_exp + {{(EW-1){1'b0}}, top};
    assign round_up = guard && (sticky || mant_n[0]);
    assign mant_r   = {1'b0, mant_n} + {{MAN_W{1'b0}}, round_up};
    // A carry out of rounding leaves the stored mantissa all-zero; only the exponent moves.
    assign exp_f    = exp_n + {{(EW-1){1'b0}}, mant_r[MAN_W]};
    assign ovf      = (exp_f >= EXP_MAX);
    assign unf      = exp_f[EW-1] || (exp_f == '0);

    always_comb begin
        res_c = {s2_sign, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
        if (s2_inv) begin
            res_c = QNAN;
        end else if (s2_inf) begin
            res_c = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (s2_zero) begin
            res_c = {s2_sign, {(W-1){1'b0}}};
        end else if (ovf) begin
            res_c = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (unf) begin
            res_c = {s2_sign, {(W-1){1'b0}}};
        end
    end

`ifdef FP_MUL_FLAGS_EN
    logic [3:0] flags_c;

    // {invalid, overflow, underflow, inexact}
    always_comb begin
        flags_c = 4'b0000;
        if (s2_inv) begin
            flags_c = 4'b1000;
        end else if (s2_inf || s2_zero) begin
            flags_c = 4'b0000;
        end else if (ovf) begin
            flags_c = 4'b0101;
        end else if (unf) begin
            flags_c = 4'b0011;
        end else begin
            flags_c = {3'b000, guard || sticky};
        end
    end
`endif

    // ------------------------------------------------------------------
    // Valid bits and output register (reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            o         <= '0;
            out_tag   <= '0;
`ifdef FP_MUL_FLAGS_EN
            flags     <= 4'b0000;
`endif
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            // Bubbles leave the last result on o rather than loading junk.
            if (s2_valid) begin
                o       <= res_c;
                out_tag <= s2_tag;
`ifdef FP_MUL_FLAGS_EN
                flags   <= flags_c;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers (no reset needed: qualified by the valid bits)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_tag  <= in_tag;
            s1_sign <= a[W-1] ^ b[W-1];
            s1_exp  <= exp_sum_c;
            s1_siga <= {1'b1, ma};
            s1_sigb <= {1'b1, mb};
            s1_inv  <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
            s1_inf  <= a_inf || b_inf;
            s1_zero <= a_zero || b_zero;

            s2_tag  <= s1_tag;
            s2_sign <= s1_sign;
            s2_exp  <= s1_exp;
            s2_prod <= prod_c;
            s2_inv  <= s1_inv;
            s2_inf  <= s1_inf;
            s2_zero <= s1_zero;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: self-checking bench for fp_mul_pipe (binary32 defaults, 4-bit tag).
module tb_fp_mul_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 4;
    localparam int W     = EXP_W + MAN_W + 1;
    localparam int QW    = 4 + TAG_W + W;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, o;
    logic [TAG_W-1:0] in_tag, out_tag;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0] flags;
`endif

    always #5 clk = ~clk;

    fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .in_tag(in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .o(o),
        .out_tag(out_tag)
`ifdef FP_MUL_FLAGS_EN
        ,
        .flags(flags)
`endif
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    int ready_mode = 0;      // 0: always 1, 1: random, 2: forced, 3: toggle
    logic ready_force = 1'b1;
    logic [QW-1:0] exp_q[$]; // {flags, tag, o}
    logic [QW-1:0] e;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] o;
        logic [3:0]  f;
    } vec_t;
    vec_t tbl[18];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference model: exact product as a real, then scaled and rounded
    // arithmetically. Returns {flags, o}.
    function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        int  ex = int'(x[30:23]);
        int  ey = int'(y[30:23]);
        logic s = x[31] ^ y[31];
        bit  zx = (ex == 0);
        bit  zy = (ey == 0);
        bit  ix = (ex == 255) && (x[22:0] == 0);
        bit  iy = (ey == 255) && (y[22:0] == 0);
        bit  nx = (ex == 255) && (x[22:0] != 0);
        bit  ny = (ey == 255) && (y[22:0] != 0);
        real mag, fl, fr;
        int  e2, sig, be;
        bit  inx;
        if (nx || ny || (ix && zy) || (iy && zx)) return {4'b1000, 32'h7FC00000};
        if (ix || iy) return {4'b0000, s, 8'hFF, 23'h0};
        if (zx || zy) return {4'b0000, s, 31'h0};
        mag = real'(int'({1'b1, x[22:0]})) * real'(int'({1'b1, y[22:0]}));
        e2  = ex + ey - 300;                 // value = mag * 2^e2
        while (mag >= 16777216.0) begin
            mag = mag / 2.0;
            e2++;
        end
        fl  = $floor(mag);
        fr  = mag - fl;
        sig = $rtoi(fl);
        inx = (fr != 0.0);
        if (fr > 0.5 || (fr == 0.5 && (sig % 2) == 1)) sig++;
        if (sig == 16777216) begin
            sig = 8388608;
            e2++;
        end
        be = e2 + 150;
        if (be >= 255) return {4'b0101, s, 8'hFF, 23'h0};
        if (be <= 0)   return {4'b0011, s, 31'h0};
        return {3'b000, inx, s, be[7:0], sig[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int unsigned r = $urandom_range(0, 15);
        logic [31:0] v = $urandom;
        case (r)
            0:       v[30:0]  = 31'h0;
            1:       v[30:0]  = {8'hFF, 23'h0};
            2:       begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3:       v[30:23] = 8'h00;
            4:       v[30:23] = 8'($urandom_range(230, 254));
            5:       v[30:23] = 8'($urandom_range(1, 30));
            default: v[30:23] = 8'($urandom_range(90, 164));
        endcase
        return v;
    endfunction

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = ready_force;
                default: out_ready = !out_ready;
            endcase
        end
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got o=%h tag=%0h, expected no output", o, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("o", o, e[W-1:0]);
                    check("tag", out_tag, e[W+TAG_W-1:W]);
`ifdef FP_MUL_FLAGS_EN
                    check("flags", flags, e[QW-1:W+TAG_W]);
`endif
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end at posedge+1.
    task automatic drive_pair(input logic [31:0] xa, input logic [31:0] xb, input logic [TAG_W-1:0] t,
                              input logic [31:0] eo, input logic [3:0] ef);
        bit ok = 0;
        a = xa; b = xb; in_tag = t; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) exp_q.push_back({ef, t, eo});
        else begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready=%0b, expected 1 within 200 cycles", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input logic [TAG_W-1:0] t);
        logic [31:0] x, y;
        logic [35:0] r;
        x = rand_op();
        y = rand_op();
        r = ref_mul(x, y);
        drive_pair(x, y, t, r[31:0], r[35:32]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        bit done = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Single pair into an empty pipeline: out_valid must rise exactly 3 cycles after accept.
    task automatic latency_check(input logic [31:0] xa, input logic [31:0] xb, input logic [TAG_W-1:0] t,
                                 input logic [31:0] eo, input logic [3:0] ef);
        a = xa; b = xb; in_tag = t; in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", in_ready, 1'b1);
        exp_q.push_back({ef, t, eo});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("lat_out_valid", out_valid, (k == 3));
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- global time limit ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int start;
        logic [TAG_W-1:0] rt;

        tbl[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000};
        tbl[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
        tbl[2]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
        tbl[3]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
        tbl[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101};
        tbl[5]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
        tbl[6]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000};
        tbl[7]  = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
        tbl[8]  = '{32'h00400000, 32'h40000000, 32'h00000000, 4'b0000};
        tbl[9]  = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 4'b0000};
        tbl[10] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000};
        tbl[11] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000};
        tbl[12] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001};
        tbl[13] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};
        tbl[14] = '{32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000};
        tbl[15] = '{32'hFF800000, 32'h7F800000, 32'hFF800000, 4'b0000};
        tbl[16] = '{32'h7F7FFFFF, 32'h3F800001, 32'h7F800000, 4'b0101};
        tbl[17] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_o", o, 32'h0);
        check("rst_out_tag", out_tag, 4'h0);
        check("rst_in_ready", in_ready, 1'b1);
`ifdef FP_MUL_FLAGS_EN
        check("rst_flags", flags, 4'h0);
`endif
        @(posedge clk);
        #1;

        // basic product with exact latency
        latency_check(32'h40000000, 32'h40400000, 4'h1, 32'h40C00000, 4'b0000);

        // table vectors streamed back to back
        for (int i = 0; i < 18; i++)
            drive_pair(tbl[i].a, tbl[i].b, TAG_W'(i), tbl[i].o, tbl[i].f);
        wait_drain();

        // backpressure: 8 pairs, out_ready low for 5 cycles mid-stream
        start = n_out;
        fork
            begin
                for (int t = 0; t < 8; t++) drive_rand(TAG_W'(t));
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                ready_force = 1'b0;
                ready_mode  = 2;
                repeat (5) @(posedge clk);
                #1;
                ready_mode  = 0;
            end
        join
        wait_drain();
        check("bp_result_count", n_out - start, 8);

        // in_valid drops while stalled; inputs change to junk meanwhile
        start = n_out;
        ready_force = 1'b0;
        ready_mode  = 2;
        for (int t = 0; t < 3; t++) drive_rand(TAG_W'(t + 8));
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom; in_tag = 4'hF;
            @(posedge clk);
            #1;
        end
        ready_mode = 0;
        wait_drain();
        check("drop_result_count", n_out - start, 3);

        // out_ready toggling every cycle
        start = n_out;
        ready_mode = 3;
        for (int t = 0; t < 20; t++) drive_rand(TAG_W'(t));
        wait_drain();
        ready_mode = 0;
        check("toggle_result_count", n_out - start, 20);

        // randomized traffic with random backpressure and input gaps
        start = n_out;
        rt = '0;
        ready_mode = 1;
        for (int n = 0; n < 300; n++) begin
            drive_rand(rt);
            rt = rt + 1'b1;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        wait_drain();
        ready_mode = 0;
        check("rand_result_count", n_out - start, 300);

        // reset with three results in flight
        ready_mode = 0;
        for (int t = 0; t < 3; t++) drive_rand(TAG_W'(t + 4));
        in_valid    = 1'b0;
        ready_force = 1'b0;
        ready_mode  = 2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_stale", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        latency_check(32'h3FC00000, 32'h3FC00000, 4'h9, 32'h40100000, 4'b0000);

        idle(4);
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
